// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM link: opcodes, frame layout and widths.
// The master and the slave-side blocks both import this package.
package spi_ram_pkg;
  localparam int OP_W    = 2;
  localparam int DATA_W  = 8;
  localparam int FRAME_W = OP_W + DATA_W;

  localparam logic [OP_W-1:0] OP_WR_ADDR = 2'b00;
  localparam logic [OP_W-1:0] OP_WR_DATA = 2'b01;
  localparam logic [OP_W-1:0] OP_RD_ADDR = 2'b10;
  localparam logic [OP_W-1:0] OP_RD_DATA = 2'b11;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] data;
  } frame_t;
endpackage

// File: rtl/spi_master_if.sv
// Host command/response handshake plus the SPI pins of the master.
interface spi_master_if;
  import spi_ram_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [OP_W-1:0]   req_op;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
  logic              ss_n;
  logic              mosi;
  logic              miso;

  modport master (
    input  req_valid, req_op, req_data, miso,
    output req_ready, rsp_valid, rsp_data, busy, ss_n, mosi
  );

  modport slave (
    output req_valid, req_op, req_data, miso,
    input  req_ready, rsp_valid, rsp_data, busy, ss_n, mosi
  );
endinterface

// File: rtl/spi_master.sv
// SPI master: shifts a 10-bit {op,data} frame out MSB first; read-data frames
// add a turnaround and an 8-bit capture. SPI bit clock is clk itself.
module spi_master
  import spi_ram_pkg::*;
#(
  parameter int TA_CYCLES  = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, SEND, TURN, RECV, GAP} state_e;

  state_e            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic [FRAME_W-1:0] frame;
  logic              is_rd;
  logic [DATA_W-2:0] rx_sh;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_valid;
  logic              accept;
  logic              rx_done;
  frame_t            req;

  assign req    = '{op: bus.req_op, data: bus.req_data};
  assign accept = bus.req_valid && bus.req_ready;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 4'd1;
    rx_done  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (accept) state_nx = SEND;
      end
      SEND: if (cnt == 4'(FRAME_W - 1)) begin
        cnt_nx   = '0;
        state_nx = is_rd ? TURN : GAP;
      end
      TURN: if (cnt == 4'(TA_CYCLES - 1)) begin
        cnt_nx   = '0;
        state_nx = RECV;
      end
      RECV: if (cnt == 4'(DATA_W - 1)) begin
        cnt_nx   = '0;
        state_nx = GAP;
        rx_done  = 1'b1;
      end
      GAP: if (cnt == 4'(GAP_CYCLES - 1)) begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      frame     <= '0;
      is_rd     <= 1'b0;
      rx_sh     <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      rsp_valid <= rx_done;
      // Frame is latched once; later req_* changes never reach mosi.
      if (accept) begin
        frame <= req;
        is_rd <= (req.op == OP_RD_DATA);
      end else if (state == SEND) begin
        frame <= {frame[FRAME_W-2:0], 1'b0};
      end
      if (state == RECV) rx_sh <= {rx_sh[DATA_W-3:0], bus.miso};
      if (rx_done) rsp_data <= {rx_sh, bus.miso};
    end
  end

  // Ready is masked by reset so nothing is advertised while rst_n is low.
  assign bus.req_ready = rst_n && (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.ss_n      = !(state inside {SEND, TURN, RECV});
  assign bus.mosi      = (state == SEND) && frame[FRAME_W-1];
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master against a behavioural SPI slave + RAM model,
// with a read-data scoreboard and an ss_n/mosi frame monitor.
module tb_spi_master;
  import spi_ram_pkg::*;

  localparam int TA  = 2;
  localparam int GAP = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  spi_master_if bus ();

  spi_master #(.TA_CYCLES(TA), .GAP_CYCLES(GAP)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave + RAM model ----------------
  logic [4:0] s_cnt = '0;
  logic [9:0] s_sh = '0;
  logic [7:0] s_addr = '0;
  logic [7:0] s_tx = '0;
  logic [7:0] mem [256];
  logic [9:0] s_f;
  int         sj;
  logic       miso_m;

  assign s_f = {s_sh[8:0], bus.mosi};

  always @(posedge clk) begin
    if (bus.ss_n) s_cnt <= '0;
    else begin
      s_cnt <= s_cnt + 5'd1;
      if (s_cnt < 5'd10) s_sh <= s_f;
      if (s_cnt == 5'd9) begin
        case (s_f[9:8])
          2'b00:   s_addr <= s_f[7:0];
          2'b01:   mem[s_addr] <= s_f[7:0];
          2'b10:   s_addr <= s_f[7:0];
          default: s_tx <= mem[s_addr];
        endcase
      end
    end
  end

  always_comb begin
    sj     = int'(s_cnt) - 10 - TA;
    miso_m = 1'b0;
    if (!bus.ss_n && sj >= 0 && sj < 8) miso_m = s_tx[7-sj];
  end
  assign bus.miso = miso_m;

  // ---------------- monitors / scoreboard ----------------
  logic [7:0] exp_q [$];
  logic [7:0] exp_b;
  logic       prev_rv = 1'b0;
  int         rsp_cnt = 0, acc_cnt = 0, mosi_bad = 0;
  int         low_cnt = 0, hi_cnt = 0, hi_busy = 0;
  int         last_len = 0, last_gap = 0, last_gap_busy = 0;
  logic [9:0] bits = '0, last_bits = '0;

  always @(posedge clk)
    if (rst_n && bus.req_valid && bus.req_ready) acc_cnt++;

  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      chk("rsp_one_cycle", 32'(prev_rv), 0);
      chk("rsp_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        exp_b = exp_q.pop_front();
        chk("rsp_data", 32'(bus.rsp_data), 32'(exp_b));
      end
      rsp_cnt++;
    end
    prev_rv = bus.rsp_valid;
    if ((bus.ss_n || low_cnt >= 10) && bus.mosi) mosi_bad++;
    if (!bus.ss_n) begin
      if (low_cnt == 0) begin
        last_gap      = hi_cnt;
        last_gap_busy = hi_busy;
      end
      if (low_cnt < 10) bits = {bits[8:0], bus.mosi};
      low_cnt++;
      hi_cnt  = 0;
      hi_busy = 0;
    end else begin
      if (low_cnt != 0) begin
        last_len  = low_cnt;
        last_bits = bits;
      end
      low_cnt = 0;
      hi_cnt++;
      if (bus.busy) hi_busy++;
    end
  end

  // Starts and ends on a negedge; lat = cycles after the accept edge until ready.
  task automatic issue(input logic [1:0] op, input logic [7:0] d, output int lat);
    int t = 0;
    while (!bus.req_ready && t < 200) begin @(negedge clk); t++; end
    chk("ready_before_issue", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_data  = d;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!bus.req_ready && lat < 200) begin lat++; @(negedge clk); end
  endtask

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < 200) begin t++; @(negedge clk); end
    chk("wait_ready_timeout", 32'(bus.req_ready), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, r0, a0, t;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_data  = '0;

    // reset: a request held during reset must not be taken
    repeat (3) @(negedge clk);
    bus.req_valid = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ready_low", 32'(bus.req_ready), 0);
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(bus.req_ready), 1);
    chk("rst_ss_n", 32'(bus.ss_n), 1);
    chk("rst_mosi", 32'(bus.mosi), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 0);
    @(negedge clk);
    chk("rst_no_accept", 32'(acc_cnt), 0);

    // write-addr 0x3C
    r0 = rsp_cnt;
    issue(OP_WR_ADDR, 8'h3C, lat);
    chk("wa_latency", 32'(lat), 32'(10 + GAP));
    chk("wa_ss_len", 32'(last_len), 10);
    chk("wa_bits", 32'(last_bits), 32'(10'b0000111100));
    chk("wa_no_rsp", 32'(rsp_cnt), 32'(r0));

    // full RAM sequence, then read-data
    issue(OP_WR_ADDR, 8'h10, lat);
    issue(OP_WR_DATA, 8'h5A, lat);
    chk("wd_bits", 32'(last_bits), 32'({OP_WR_DATA, 8'h5A}));
    issue(OP_RD_ADDR, 8'h10, lat);
    exp_q.push_back(8'h5A);
    r0 = rsp_cnt;
    issue(OP_RD_DATA, 8'h00, lat);
    chk("rd_latency", 32'(lat), 32'(10 + TA + 8 + GAP));
    chk("rd_ss_len", 32'(last_len), 32'(10 + TA + 8));
    chk("rd_rsp_cnt", 32'(rsp_cnt), 32'(r0 + 1));
    chk("rd_rsp_hold", 32'(bus.rsp_data), 32'h5A);

    // read-data returning 0xA5
    issue(OP_WR_ADDR, 8'h20, lat);
    issue(OP_WR_DATA, 8'hA5, lat);
    issue(OP_RD_ADDR, 8'h20, lat);
    exp_q.push_back(8'hA5);
    issue(OP_RD_DATA, 8'hFF, lat);
    chk("rd2_ss_len", 32'(last_len), 32'(10 + TA + 8));
    chk("rd2_bits", 32'(last_bits), 32'({OP_RD_DATA, 8'hFF}));

    // back-to-back: valid held high across two frames
    a0 = acc_cnt;
    bus.req_valid = 1'b1;
    bus.req_op    = OP_WR_ADDR;
    bus.req_data  = 8'h11;
    @(posedge clk); #1;
    bus.req_op    = OP_WR_DATA;
    bus.req_data  = 8'h22;
    t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < 200) begin t++; @(negedge clk); end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_ready();
    repeat (3) @(negedge clk);
    chk("b2b_accepts", 32'(acc_cnt - a0), 2);
    chk("b2b_gap_state", 32'(last_gap_busy), 32'(GAP));
    chk("b2b_ss_high", 32'(last_gap), 32'(GAP + 1));
    chk("b2b_bits", 32'(last_bits), 32'({OP_WR_DATA, 8'h22}));

    // req_data/op change mid-SEND must not reach mosi
    bus.req_valid = 1'b1;
    bus.req_op    = OP_WR_DATA;
    bus.req_data  = 8'hC3;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    bus.req_op   = OP_RD_DATA;
    bus.req_data = 8'h00;
    wait_ready();
    chk("midsend_bits", 32'(last_bits), 32'({OP_WR_DATA, 8'hC3}));
    chk("midsend_len", 32'(last_len), 10);

    // reset during RECV: abort, no response, rsp_data cleared
    r0 = rsp_cnt;
    bus.req_valid = 1'b1;
    bus.req_op    = OP_RD_DATA;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (10 + TA + 4) @(negedge clk);
    chk("abort_in_frame", 32'(bus.ss_n), 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ss_n", 32'(bus.ss_n), 1);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("abort_rsp_data", 32'(bus.rsp_data), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    rst_n = 1'b1;
    #1;
    chk("abort_ready", 32'(bus.req_ready), 1);
    repeat (20) @(negedge clk);
    chk("abort_no_rsp", 32'(rsp_cnt), 32'(r0));

    chk("sb_empty", 32'(exp_q.size()), 0);
    chk("mosi_quiet", 32'(mosi_bad), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
